change_dispenser: RTL and testbench

//  Downstream of vending_machine: takes the product code and change amount it

---
 rtl/change_dispenser_if.sv | 39 +++
 rtl/change_dispenser.sv | 120 ++++++++++++
 tb/tb_change_dispenser.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: vend request, payout pulses and status bundle (optional paid_total under CHANGE_DISPENSER_AUDIT_EN)
interface change_dispenser_if #(
  parameter int STOCK_W = 4
);
  logic               vend_valid;
  logic [3:0]         product_code;
  logic [4:0]         change_amt;
  logic               refill;
  logic               busy;
  logic               product_motor;
  logic [3:0]         product_id;
  logic               eject5;
  logic               eject10;
  logic               done;
  logic               shortfall;
  logic [4:0]         owed;
  logic [STOCK_W-1:0] stock5;
  logic [STOCK_W-1:0] stock10;
`ifdef CHANGE_DISPENSER_AUDIT_EN
  logic [11:0]        paid_total;
  modport master (
    output vend_valid, product_code, change_amt, refill,
    input  busy, product_motor, product_id, eject5, eject10, done, shortfall, owed, stock5, stock10, paid_total
  );
  modport slave (
    input  vend_valid, product_code, change_amt, refill,
    output busy, product_motor, product_id, eject5, eject10, done, shortfall, owed, stock5, stock10, paid_total
  );
`else
  modport master (
    output vend_valid, product_code, change_amt, refill,
    input  busy, product_motor, product_id, eject5, eject10, done, shortfall, owed, stock5, stock10
  );
  modport slave (
    input  vend_valid, product_code, change_amt, refill,
    output busy, product_motor, product_id, eject5, eject10, done, shortfall, owed, stock5, stock10
  );
`endif
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: product motor pulse then greedy 10/5 coin payout against stock (CHANGE_DISPENSER_AUDIT_EN adds paid_total)
module change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int STOCK_W      = 4,
  parameter int STOCK5_INIT  = 8,
  parameter int STOCK10_INIT = 8
) (
  input logic                clk,
  input logic                reset,
  change_dispenser_if.slave  bus
);
  localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] P_LD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] G_LD = CW'(GAP_CYCLES - 1);
  localparam logic [STOCK_W-1:0] S5_INIT = STOCK_W'(STOCK5_INIT);
  localparam logic [STOCK_W-1:0] S10_INIT = STOCK_W'(STOCK10_INIT);

  typedef enum logic [2:0] {IDLE, MOTOR, MGAP, PICK, COIN, CGAP, DONE} state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [4:0]  remaining;

  // Transaction sequencer: every output is a register updated here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      cnt               <= '0;
      remaining         <= '0;
      bus.busy          <= 1'b0;
      bus.product_motor <= 1'b0;
      bus.product_id    <= '0;
      bus.eject5        <= 1'b0;
      bus.eject10       <= 1'b0;
      bus.done          <= 1'b0;
      bus.shortfall     <= 1'b0;
      bus.owed          <= '0;
      bus.stock5        <= S5_INIT;
      bus.stock10       <= S10_INIT;
`ifdef CHANGE_DISPENSER_AUDIT_EN
      bus.paid_total    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.vend_valid) begin
            state             <= MOTOR;
            cnt               <= P_LD;
            remaining         <= bus.change_amt;
            bus.product_id    <= bus.product_code;
            bus.busy          <= 1'b1;
            bus.product_motor <= 1'b1;
          end else if (bus.refill) begin
            bus.stock5  <= S5_INIT;
            bus.stock10 <= S10_INIT;
          end
        end
        MOTOR: begin
          if (cnt == '0) begin
            state             <= MGAP;
            cnt               <= G_LD;
            bus.product_motor <= 1'b0;
          end else cnt <= cnt - CW'(1);
        end
        MGAP: begin
          if (cnt == '0) state <= PICK;
          else cnt <= cnt - CW'(1);
        end
        PICK: begin
          if (remaining >= 5'd10 && bus.stock10 != '0) begin
            state       <= COIN;
            cnt         <= P_LD;
            remaining   <= remaining - 5'd10;
            bus.eject10 <= 1'b1;
            bus.stock10 <= bus.stock10 - STOCK_W'(1);
`ifdef CHANGE_DISPENSER_AUDIT_EN
            bus.paid_total <= bus.paid_total + 12'd10;
`endif
          end else if (remaining >= 5'd5 && bus.stock5 != '0) begin
            state       <= COIN;
            cnt         <= P_LD;
            remaining   <= remaining - 5'd5;
            bus.eject5  <= 1'b1;
            bus.stock5  <= bus.stock5 - STOCK_W'(1);
`ifdef CHANGE_DISPENSER_AUDIT_EN
            bus.paid_total <= bus.paid_total + 12'd5;
`endif
          end else begin
            state         <= DONE;
            bus.done      <= 1'b1;
            bus.shortfall <= remaining != 5'd0;
            bus.owed      <= remaining;
          end
        end
        COIN: begin
          if (cnt == '0) begin
            state       <= CGAP;
            cnt         <= G_LD;
            bus.eject5  <= 1'b0;
            bus.eject10 <= 1'b0;
          end else cnt <= cnt - CW'(1);
        end
        CGAP: begin
          if (cnt == '0) state <= PICK;
          else cnt <= cnt - CW'(1);
        end
        DONE: begin
          state         <= IDLE;
          bus.busy      <= 1'b0;
          bus.done      <= 1'b0;
          bus.shortfall <= 1'b0;
          bus.owed      <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed vends with a queued expectation scoreboard and a done-triggered monitor
module tb_change_dispenser;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  change_dispenser_if #(.STOCK_W(4)) bus();
  change_dispenser dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int code;
    int short_f;
    int owed;
    int s5;
    int s10;
    int n5;
    int n10;
    int lat;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Each coin costs one PICK cycle, PULSE high cycles and GAP low cycles: 7 with defaults
  task automatic expect_tx(int code, int sh, int ow, int s5, int s10, int n5, int n10);
    exp_t e;
    e.code = code; e.short_f = sh; e.owed = ow; e.s5 = s5; e.s10 = s10;
    e.n5 = n5; e.n10 = n10; e.lat = 7 + 7 * (n5 + n10);
    q.push_back(e);
  endtask

  task automatic vend(int code, int amt);
    @(posedge clk); #1;
    bus.vend_valid = 1'b1;
    bus.product_code = 4'(code);
    bus.change_amt = 5'(amt);
    @(posedge clk); #1;
    bus.vend_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    chk("idle_wait", int'(bus.busy), 0);
  endtask

  task automatic pulse_refill();
    @(posedge clk); #1 bus.refill = 1'b1;
    @(posedge clk); #1 bus.refill = 1'b0;
  endtask

  int cyc = 0, start = 0, n5 = 0, n10 = 0, mot = 0, ovl = 0;
  logic p5 = 1'b0, p10 = 1'b0, pb = 1'b0;

  initial forever begin
    exp_t e;
    @(negedge clk);
    cyc++;
    if (!reset) begin
      n5 = 0; n10 = 0; mot = 0; ovl = 0; p5 = 1'b0; p10 = 1'b0; pb = 1'b0;
    end else begin
      if (bus.busy && !pb) begin
        start = cyc; n5 = 0; n10 = 0; mot = 0; ovl = 0;
      end
      if (bus.eject5 && !p5) n5++;
      if (bus.eject10 && !p10) n10++;
      if (bus.product_motor) mot++;
      if (int'(bus.product_motor) + int'(bus.eject5) + int'(bus.eject10) > 1) ovl++;
      if (bus.done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("product_id", int'(bus.product_id), e.code);
          chk("shortfall", int'(bus.shortfall), e.short_f);
          chk("owed", int'(bus.owed), e.owed);
          chk("stock5", int'(bus.stock5), e.s5);
          chk("stock10", int'(bus.stock10), e.s10);
          chk("eject5_pulses", n5, e.n5);
          chk("eject10_pulses", n10, e.n10);
          chk("motor_cycles", mot, 4);
          chk("pulse_overlap", ovl, 0);
          chk("done_latency", cyc - start, e.lat);
        end
      end
      p5 = bus.eject5; p10 = bus.eject10; pb = bus.busy;
    end
  end

  initial begin
    int found;
    bus.vend_valid = 1'b0;
    bus.refill = 1'b0;
    bus.product_code = '0;
    bus.change_amt = '0;
    #1 reset = 1'b0;
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_motor", int'(bus.product_motor), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_owed", int'(bus.owed), 0);
    chk("rst_stock5", int'(bus.stock5), 8);
    chk("rst_stock10", int'(bus.stock10), 8);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    expect_tx(1, 0, 0, 8, 8, 0, 0);  vend(1, 0);  wait_idle();
    expect_tx(2, 0, 0, 7, 7, 1, 1);  vend(2, 15); wait_idle();
    expect_tx(3, 0, 0, 7, 4, 0, 3);  vend(3, 30); wait_idle();
    expect_tx(3, 0, 0, 7, 1, 0, 3);  vend(3, 30); wait_idle();
    expect_tx(0, 0, 0, 5, 0, 2, 1);  vend(0, 20); wait_idle();
    expect_tx(1, 0, 0, 1, 0, 4, 0);  vend(1, 20); wait_idle();
    expect_tx(2, 1, 5, 0, 0, 1, 0);  vend(2, 10); wait_idle();
    expect_tx(2, 1, 10, 0, 0, 0, 0); vend(2, 10); wait_idle();

    pulse_refill();
    @(negedge clk);
    chk("refill_stock5", int'(bus.stock5), 8);
    chk("refill_stock10", int'(bus.stock10), 8);

    expect_tx(0, 1, 2, 7, 8, 1, 0);
    vend(0, 7);
    repeat (3) @(posedge clk);
    #1 bus.vend_valid = 1'b1; bus.product_code = 4'd3; bus.change_amt = 5'd15;
    @(posedge clk); #1 bus.vend_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 bus.refill = 1'b1;
    @(posedge clk); #1 bus.refill = 1'b0;
    wait_idle();

    vend(2, 15);
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.eject10) begin
        found = 1;
        break;
      end
    end
    chk("reached_coin", found, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_motor", int'(bus.product_motor), 0);
    chk("abort_eject5", int'(bus.eject5), 0);
    chk("abort_eject10", int'(bus.eject10), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_shortfall", int'(bus.shortfall), 0);
    chk("abort_product_id", int'(bus.product_id), 0);
    chk("abort_stock5", int'(bus.stock5), 8);
    chk("abort_stock10", int'(bus.stock10), 8);
    @(negedge clk);
    reset = 1'b1;

    expect_tx(3, 0, 0, 7, 8, 1, 0); vend(3, 5); wait_idle();

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
